// File: rtl/gpio_ctrl.sv
// gpio_ctrl: parametrised GPIO port with per-pin direction, atomic OUT set/clear,
// synchronised inputs and edge interrupts (W1C status). Macro GPIO_DEBOUNCE_EN adds per-pin debounce.

module gpio_pin #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic pad,
    input  logic pol,
    output logic val,
    output logic edge_hit
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], pad};
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES);
    logic [CW-1:0] cnt;
    logic          db;

    // Any single-cycle agreement with the held value restarts the window.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (sync[SYNC_STAGES-1] == db) begin
            cnt <= '0;
        end else if (cnt == CW'(DB_CYCLES - 1)) begin
            db  <= sync[SYNC_STAGES-1];
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign val = db;
`else
    assign val = sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) prev <= 1'b0;
        else       prev <= val;
    end

    assign edge_hit = pol ? (~val & prev) : (val & ~prev);
endmodule

module gpio_ctrl #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sel,
    input  logic             wen,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] datain,
    output logic [WIDTH-1:0] dataout,
    inout  wire  [WIDTH-1:0] gpio,
    output logic             irq
);
    localparam logic [2:0] A_DIR  = 3'd0;
    localparam logic [2:0] A_OUT  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_IEN  = 3'd3;
    localparam logic [2:0] A_POL  = 3'd4;
    localparam logic [2:0] A_STAT = 3'd5;
    localparam logic [2:0] A_SET  = 3'd6;
    localparam logic [2:0] A_CLR  = 3'd7;

    logic [WIDTH-1:0] dir, out, ien, pol, stat;
    logic [WIDTH-1:0] in_val, edge_vec, w1c;
    logic             wr, rd;

    assign wr = sel & wen;
    assign rd = sel & ~wen;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign gpio[i] = dir[i] ? out[i] : 1'bz;

        gpio_pin #(
            .SYNC_STAGES(SYNC_STAGES),
            .DB_CYCLES  (DB_CYCLES)
        ) u_pin (
            .clk     (clk),
            .rstn    (rstn),
            .pad     (gpio[i]),
            .pol     (pol[i]),
            .val     (in_val[i]),
            .edge_hit(edge_vec[i])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dir <= '0;
            out <= '0;
            ien <= '0;
            pol <= '0;
        end else if (wr) begin
            case (addr)
                A_DIR:   dir <= datain;
                A_OUT:   out <= datain;
                A_IEN:   ien <= datain;
                A_POL:   pol <= datain;
                A_SET:   out <= out | datain;
                A_CLR:   out <= out & ~datain;
                default: ;
            endcase
        end
    end

    // A new edge on the same clock as its W1C keeps the bit set.
    assign w1c = (wr && addr == A_STAT) ? datain : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) stat <= '0;
        else       stat <= (stat & ~w1c) | (edge_vec & ien);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dataout <= '0;
        end else if (rd) begin
            case (addr)
                A_DIR:   dataout <= dir;
                A_OUT:   dataout <= out;
                A_IN:    dataout <= in_val;
                A_IEN:   dataout <= ien;
                A_POL:   dataout <= pol;
                A_STAT:  dataout <= stat;
                default: dataout <= '0;
            endcase
        end
    end

    assign irq = |(stat & ien);
endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: register map, pad drive/release, edge interrupts,
// W1C/set collision, masking, async reset, and debounce when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_ctrl;
    localparam int W = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = 2 + 8 + 1;
`else
    localparam int LAT = 2 + 1;
`endif

    logic         clk    = 1'b0;
    logic         rstn   = 1'b0;
    logic         sel    = 1'b0;
    logic         wen    = 1'b0;
    logic [2:0]   addr   = '0;
    logic [W-1:0] datain = '0;
    logic [W-1:0] dataout;
    wire  [W-1:0] gpio;
    logic         irq;
    logic [W-1:0] tb_oe  = '0;
    logic [W-1:0] tb_val = '0;
    int           vectors = 0;
    int           errs    = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < W; i++) begin : g_pad
        assign gpio[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .DB_CYCLES(8)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .sel    (sel),
        .wen    (wen),
        .addr   (addr),
        .datain (datain),
        .dataout(dataout),
        .gpio   (gpio),
        .irq    (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        sel = 1'b1; wen = 1'b1; addr = a; datain = d;
        tick();
        sel = 1'b0; wen = 1'b0; datain = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [W-1:0] exp);
        sel = 1'b1; wen = 1'b0; addr = a;
        tick();
        sel = 1'b0;
        check(tag, 32'(dataout), 32'(exp));
    endtask

    initial begin
        // 1: reset state and all-zero reads
        tb_oe = 16'hFFFF; tb_val = 16'h0000;
        #12;
        check("rst_dataout", 32'(dataout), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        @(posedge clk); #3 rstn = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) rd_chk("t1_rd", 3'(a), 16'h0000);
        check("t1_irq", 32'(irq), 32'h0);

        // 2: direction, output value, set/clear, read-only IN
        tb_oe = 16'hFF00;
        wr(3'd0, 16'h00FF);
        wr(3'd1, 16'h00A5);
        check("t2_pad_lo", 32'(gpio[7:0]), 32'hA5);
        wr(3'd6, 16'h0002);
        wr(3'd7, 16'h0001);
        rd_chk("t2_out", 3'd1, 16'h00A6);
        rd_chk("t2_dir", 3'd0, 16'h00FF);
        rd_chk("t2_set_rd0", 3'd6, 16'h0000);
        rd_chk("t2_clr_rd0", 3'd7, 16'h0000);
        wr(3'd6, 16'hFF00);
        check("t2_hi_released", 32'(gpio), 32'h00A6);
        rd_chk("t2_out_set_hi", 3'd1, 16'hFFA6);
        wr(3'd7, 16'hFF00);
        repeat (LAT) tick();
        rd_chk("t2_in", 3'd2, 16'h00A6);
        wr(3'd2, 16'hFFFF);
        rd_chk("t2_in_ro", 3'd2, 16'h00A6);

        // 3: rising edge on pin 8, exact latency, W1C
        wr(3'd3, 16'h0100);
        wr(3'd4, 16'h0000);
        tb_val[8] = 1'b1;
        repeat (LAT - 1) tick();
        check("t3_irq_early", 32'(irq), 32'h0);
        tick();
        check("t3_irq_set", 32'(irq), 32'h1);
        rd_chk("t3_stat", 3'd5, 16'h0100);
        wr(3'd5, 16'h0100);
        check("t3_irq_clr", 32'(irq), 32'h0);
        rd_chk("t3_stat_clr", 3'd5, 16'h0000);

        // 4: falling polarity, W1C colliding with a new edge
        wr(3'd4, 16'h0200);
        wr(3'd3, 16'h0300);
        tb_val[9] = 1'b1;
        repeat (LAT + 1) tick();
        rd_chk("t4_rise_ignored", 3'd5, 16'h0000);
        tb_val[9] = 1'b0;
        repeat (LAT - 1) tick();
        wr(3'd5, 16'h0200);
        check("t4_irq_set_wins", 32'(irq), 32'h1);
        rd_chk("t4_stat_set_wins", 3'd5, 16'h0200);
        wr(3'd5, 16'h0200);
        rd_chk("t4_stat_cleared", 3'd5, 16'h0000);
        tb_val[9] = 1'b1;
        repeat (LAT + 1) tick();
        rd_chk("t4_rise_no_set", 3'd5, 16'h0000);
        check("t4_irq_quiet", 32'(irq), 32'h0);

        // 5: edge while disabled is discarded; async reset releases pads
        tb_val[10] = 1'b1;
        repeat (LAT + 2) tick();
        tb_val[10] = 1'b0;
        repeat (LAT + 2) tick();
        wr(3'd3, 16'h0700);
        repeat (LAT) tick();
        rd_chk("t5_masked_edge", 3'd5, 16'h0000);
        check("t5_irq_masked", 32'(irq), 32'h0);
        tb_val[9] = 1'b0;
        repeat (LAT) tick();
        check("t5_irq_pre_rst", 32'(irq), 32'h1);
        wr(3'd1, 16'hFFFF);
        tb_oe = 16'h0000;
        wr(3'd0, 16'hFFFF);
        check("t5_pad_driven", 32'(gpio), 32'hFFFF);
        rd_chk("t5_dir_all", 3'd0, 16'hFFFF);
        @(posedge clk);
        #3;
        rstn = 1'b0; tb_oe = 16'hFFFF; tb_val = 16'h0000;
        #1;
        check("t5_rst_pad_release", 32'(gpio), 32'h0);
        check("t5_rst_irq", 32'(irq), 32'h0);
        check("t5_rst_dataout", 32'(dataout), 32'h0);
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) rd_chk("t5_post_rst_rd", 3'(a), 16'h0000);

`ifdef GPIO_DEBOUNCE_EN
        // 6: short pulse rejected, long pulse accepted at SYNC+DB+1
        wr(3'd3, 16'h0008);
        tb_val[3] = 1'b1;
        repeat (5) tick();
        tb_val[3] = 1'b0;
        repeat (15) tick();
        rd_chk("t6_short_in", 3'd2, 16'h0000);
        check("t6_short_irq", 32'(irq), 32'h0);
        tb_val[3] = 1'b1;
        repeat (10) tick();
        check("t6_irq_early", 32'(irq), 32'h0);
        tick();
        check("t6_irq_set", 32'(irq), 32'h1);
        rd_chk("t6_in", 3'd2, 16'h0008);
        rd_chk("t6_stat", 3'd5, 16'h0008);
        tb_val[3] = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
